// File: rtl/gpio_button_fifo.sv
// fifo_fwft: generic first-word-fall-through FIFO, register-array storage.
// Latency: a push is visible on rd_dat after its edge; rd_dat shows the head with zero read latency.
// Backpressure: rejected writes (full, no pop) pulse drop; pops while empty are ignored.
//
// Ports: clk/rst_n; wr_vld/wr_dat push side; rd_vld pop request; rd_dat head entry (0 when empty);
//        empty/full/count decoded from the count register; drop flags a rejected write this cycle.
module fifo_fwft #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_vld,
  input  logic [W-1:0]             wr_dat,
  input  logic                     rd_vld,
  output logic [W-1:0]             rd_dat,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W = DEPTH;
  localparam logic [AW:0] FULL_CNT = DEPTH_W[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);
  assign count = cnt;

  // A pop only happens with data present; a full FIFO still accepts a
  // write when a pop frees the head slot on the same edge.
  assign do_pop  = rd_vld & ~empty;
  assign do_push = wr_vld & (~full | do_pop);
  assign drop    = wr_vld & ~do_push;

  // Stale storage is masked so an empty FIFO always presents zero.
  assign rd_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + {{AW{1'b0}}, 1'b1};
        2'b01:   cnt <= cnt - {{AW{1'b0}}, 1'b1};
        default: cnt <= cnt;
      endcase
    end
  end

  // Data contents need no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_dat;
  end
endmodule

// gpio_button_fifo: synchronise button levels, detect presses, queue one press mask per cycle.
// Latency: a level sampled at edge N is pushed at edge N+SYNC_STAGES; fifo_empty falls after that edge.
// Backpressure: none toward the buttons; a press arriving while full with no pop is dropped and sets overflow.
//
// Ports: clk, rst_n (async active-low); buttons (async levels, 1 = pressed); fifo_rd_en pop;
//        ovf_clr clears overflow; fifo_data head mask (0 when empty); fifo_empty/full/count status;
//        overflow sticky drop flag.
module gpio_button_fifo #(
  parameter int WIDTH       = 3,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         buttons,
  input  logic                     fifo_rd_en,
  input  logic                     ovf_clr,
  output logic [WIDTH-1:0]         fifo_data,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise;
  logic             push_vld;
  logic             drop;

  // Per-bit synchroniser chain followed by the edge-history register.
  // prev_q resets to 0, so a button held through reset release yields one event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= buttons;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Whole rise mask is one entry: simultaneous presses share it, releases never push.
  assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign push_vld = |rise;

  fifo_fwft #(
    .W     (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (push_vld),
    .wr_dat (rise),
    .rd_vld (fifo_rd_en),
    .rd_dat (fifo_data),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .count  (fifo_count),
    .drop   (drop)
  );

  // Sticky drop flag; a drop on the same edge as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_gpio_button_fifo.sv
// tb_gpio_button_fifo: directed and randomised checks of gpio_button_fifo against a queue-based model.
// Latency: outputs are sampled on the falling edge, one half-cycle after the edge that updates them.
// Backpressure: the bench drives fifo_rd_en freely, including pops while empty and while full.
module tb_gpio_button_fifo;
  localparam int W     = 3;
  localparam int DEPTH = 8;
  localparam int SYNC  = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  buttons;
  logic          fifo_rd_en;
  logic          ovf_clr;
  logic [W-1:0]  fifo_data;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gpio_button_fifo #(
    .WIDTH       (W),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .buttons    (buttons),
    .fifo_rd_en (fifo_rd_en),
    .ovf_clr    (ovf_clr),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  // Reference model: a press is seen SYNC edges after sampling; an entry
  // is the set of buttons whose delayed level went 0 -> 1. Queue semantics:
  // pop first (if data), then push if there is room, else flag a drop.
  logic [W-1:0] mq [$];
  bit           m_ovf;
  logic [W-1:0] hist [0:SYNC];   // hist[k] = buttons sampled k+1 edges ago
  logic [W-1:0] m_rise;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      for (int i = 0; i <= SYNC; i++) hist[i] = '0;
    end else begin
      m_rise = hist[SYNC-1] & ~hist[SYNC];
      if (fifo_rd_en && mq.size() > 0) void'(mq.pop_front());
      if (m_rise != '0 && mq.size() >= DEPTH) m_ovf = 1'b1;
      else begin
        if (m_rise != '0) mq.push_back(m_rise);
        if (ovf_clr) m_ovf = 1'b0;
      end
      for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = buttons;
    end
  end

  // Drive inputs, then advance to the next falling edge.
  task automatic tick(input logic [W-1:0] b, input logic rd, input logic clr);
    buttons    = b;
    fifo_rd_en = rd;
    ovf_clr    = clr;
    @(negedge clk);
  endtask

  task automatic press(input logic [W-1:0] p);
    tick(p, 1'b0, 1'b0);
    tick(p, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; buttons = '0; fifo_rd_en = 1'b0; ovf_clr = 1'b0;
    for (int c = 0; c < 6; c++) begin
      buttons = W'($urandom);
      @(negedge clk);
      checks++;
      if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
        errors++;
        $display("FAIL reset_flags: empty=%b full=%b, want empty=1 full=0", fifo_empty, fifo_full);
      end
      checks++;
      if (fifo_count !== '0 || fifo_data !== '0 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL reset_vals: count=%0d data=%b ovf=%b, want all 0", fifo_count, fifo_data, overflow);
      end
    end
    buttons = '0;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) tick('0, 1'b0, 1'b0);
    checks++;
    if (fifo_empty !== 1'b1 || fifo_count !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: empty=%b count=%0d, want 1/0", fifo_empty, fifo_count);
    end
  endtask

  task automatic test_single_press;
    tick(3'b010, 1'b0, 1'b0);   // sampled at edge N
    tick(3'b010, 1'b0, 1'b0);   // after edge N+1
    checks++;
    if (fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL single_early: empty=%b after N+1, want 1", fifo_empty);
    end
    tick(3'b010, 1'b0, 1'b0);   // after edge N+2
    checks++;
    if (fifo_empty !== 1'b0 || fifo_data !== 3'b010 || fifo_count !== CW'(1)) begin
      errors++;
      $display("FAIL single_push: empty=%b data=%b count=%0d, want 0/010/1", fifo_empty, fifo_data, fifo_count);
    end
    for (int c = 0; c < 4; c++) tick(3'b010, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) tick(3'b000, 1'b0, 1'b0);
    checks++;
    if (fifo_count !== CW'(1)) begin
      errors++;
      $display("FAIL single_hold_release: count=%0d, want 1", fifo_count);
    end
    tick('0, 1'b1, 1'b0);
    checks++;
    if (fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL single_drain: empty=%b, want 1", fifo_empty);
    end
  endtask

  task automatic test_simultaneous_drain;
    for (int c = 0; c < 3; c++) tick(3'b101, 1'b0, 1'b0);
    checks++;
    if (fifo_data !== 3'b101 || fifo_count !== CW'(1)) begin
      errors++;
      $display("FAIL simul_entry: data=%b count=%0d, want 101/1", fifo_data, fifo_count);
    end
    tick(3'b101, 1'b1, 1'b0);
    checks++;
    if (fifo_empty !== 1'b1 || fifo_data !== '0) begin
      errors++;
      $display("FAIL simul_pop: empty=%b data=%b, want 1/000", fifo_empty, fifo_data);
    end
    tick(3'b101, 1'b1, 1'b0);
    checks++;
    if (fifo_count !== '0 || fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL pop_empty: count=%0d empty=%b, want 0/1", fifo_count, fifo_empty);
    end
    tick('0, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0);
  endtask

  task automatic test_fill_overflow_wrap;
    logic [W-1:0] exp;
    for (int i = 0; i < 9; i++) begin
      exp = 3'b001 << (i % 3);
      press(exp);
      if (i == 7) begin
        checks++;
        if (fifo_count !== CW'(DEPTH) || overflow !== 1'b0) begin
          errors++;
          $display("FAIL fill_8: count=%0d ovf=%b, want 8/0", fifo_count, overflow);
        end
      end
    end
    checks++;
    if (fifo_full !== 1'b1 || fifo_count !== CW'(DEPTH) || overflow !== 1'b1) begin
      errors++;
      $display("FAIL fill_9th: full=%b count=%0d ovf=%b, want 1/8/1", fifo_full, fifo_count, overflow);
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp = 3'b001 << (i % 3);
      checks++;
      if (fifo_data !== exp) begin
        errors++;
        $display("FAIL drain_order[%0d]: data=%b, want %b", i, fifo_data, exp);
      end
      tick('0, 1'b1, 1'b0);
    end
    checks++;
    if (fifo_empty !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL drained: empty=%b ovf=%b, want 1/1", fifo_empty, overflow);
    end
    for (int i = 0; i < 5; i++) press(3'b001 << (i % 3));
    for (int i = 0; i < 5; i++) begin
      exp = 3'b001 << (i % 3);
      checks++;
      if (fifo_data !== exp) begin
        errors++;
        $display("FAIL refill_order[%0d]: data=%b, want %b", i, fifo_data, exp);
      end
      tick('0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_full_push_pop;
    logic [W-1:0] exp;
    tick('0, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: ovf=%b, want 0", overflow);
    end
    for (int i = 0; i < DEPTH; i++) press(W'((i % 7) + 1));
    checks++;
    if (fifo_full !== 1'b1 || fifo_data !== 3'b001) begin
      errors++;
      $display("FAIL refill_full: full=%b head=%b, want 1/001", fifo_full, fifo_data);
    end
    tick(3'b111, 1'b0, 1'b0);
    tick(3'b111, 1'b0, 1'b0);
    tick(3'b111, 1'b1, 1'b0);   // pop lands on the same edge as the push
    checks++;
    if (fifo_count !== CW'(DEPTH) || overflow !== 1'b0 || fifo_data !== 3'b010) begin
      errors++;
      $display("FAIL full_push_pop: count=%0d ovf=%b head=%b, want 8/0/010", fifo_count, overflow, fifo_data);
    end
    tick('0, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      exp = (i == DEPTH - 1) ? 3'b111 : W'(((i + 1) % 7) + 1);
      checks++;
      if (fifo_data !== exp) begin
        errors++;
        $display("FAIL pp_order[%0d]: data=%b, want %b", i, fifo_data, exp);
      end
      tick('0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_random(input int ncyc, input int rd_pct);
    logic [W-1:0] exp_dat;
    for (int c = 0; c < ncyc; c++) begin
      tick(W'($urandom), ($urandom_range(99) < rd_pct), ($urandom_range(99) < 8));
      exp_dat = (mq.size() == 0) ? '0 : mq[0];
      checks++;
      if (fifo_count !== CW'(mq.size())) begin
        errors++;
        $display("FAIL rnd_count@%0d: count=%0d, want %0d", c, fifo_count, mq.size());
      end
      checks++;
      if (fifo_data !== exp_dat) begin
        errors++;
        $display("FAIL rnd_data@%0d: data=%b, want %b", c, fifo_data, exp_dat);
      end
      checks++;
      if (fifo_empty !== (mq.size() == 0) || fifo_full !== (mq.size() == DEPTH)) begin
        errors++;
        $display("FAIL rnd_flags@%0d: empty=%b full=%b, model size %0d", c, fifo_empty, fifo_full, mq.size());
      end
      checks++;
      if (overflow !== m_ovf) begin
        errors++;
        $display("FAIL rnd_ovf@%0d: ovf=%b, want %b", c, overflow, m_ovf);
      end
    end
    tick('0, 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset;
    for (int c = 0; c < 3 * DEPTH && mq.size() > 0; c++) tick('0, 1'b1, 1'b0);
    tick('0, 1'b0, 1'b0);
    press(3'b001); press(3'b010); press(3'b100); press(3'b011);
    checks++;
    if (fifo_count !== CW'(4) || fifo_data !== 3'b001) begin
      errors++;
      $display("FAIL async_pre: count=%0d head=%b, want 4/001", fifo_count, fifo_data);
    end
    buttons = 3'b111;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (fifo_empty !== 1'b1 || fifo_count !== '0 || fifo_data !== '0 || fifo_full !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: empty=%b count=%0d data=%b full=%b, want 1/0/000/0",
               fifo_empty, fifo_count, fifo_data, fifo_full);
    end
    @(negedge clk);
    tick(3'b111, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(3'b111, 1'b0, 1'b0);
    tick(3'b111, 1'b0, 1'b0);
    checks++;
    if (fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL held_early: empty=%b, want 1", fifo_empty);
    end
    tick(3'b111, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) tick(3'b111, 1'b0, 1'b0);
    checks++;
    if (fifo_count !== CW'(1) || fifo_data !== 3'b111) begin
      errors++;
      $display("FAIL held_through_reset: count=%0d data=%b, want 1/111", fifo_count, fifo_data);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_simultaneous_drain();
    test_fill_overflow_wrap();
    test_full_push_pop();
    test_random(250, 35);
    test_random(250, 75);
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1);
  end
endmodule
